// File: rtl/cpu32_pkg.sv
// rtl/cpu32_pkg.sv - shared widths, reset address, fetch FSM encoding and buffer entry type
package cpu32_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] PC_STEP          = 32'd4;
    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Fetch FSM encoding
    typedef logic [0:0] fetch_state_t;
    localparam fetch_state_t IDLE = 1'b0;
    localparam fetch_state_t RUN  = 1'b1;

    // One instruction buffer slot: fetched word plus the address it came from
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry instruction buffer of {instr, pc} with dominant flush
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   push, push_data   write an entry at the tail (ignored when full)
//   pop               drop the head entry (ignored when empty)
//   flush             discard all entries; wins over push and pop
//   full, empty       occupancy flags
//   head              registered head entry; stale when empty
module fetch_fifo
    import cpu32_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Storage is cleared on reset so ir/ir_pc read as zero out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end: fetch PC, imem req/ack, buffer, decode handshake
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   imem_req, imem_addr       fetch request and word-aligned address
//   imem_ack, imem_rdata      memory accept with same-cycle instruction word
//   redirect, redirect_pc     taken branch and its target (flushes the buffer)
//   ir_valid, ir, ir_pc       instruction to decode and its address
//   ir_ready                  decode accepts ir this cycle
//   perf_bubbles, perf_flushes  saturating counters, present only with FETCH_PERF_EN
module fetch_unit
    import cpu32_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int                DEPTH    = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               ir_valid,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc,
    input  logic               ir_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_bubbles,
    output logic [15:0]        perf_flushes
`endif
);

    localparam logic [ADDR_W-1:0] PC_MASK = ~32'h3;

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] fetch_pc_d;
    logic              fifo_full;
    logic              fifo_empty;
    logic              do_push;
    logic              do_pop;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    assign imem_req  = (state_q == RUN) & ~fifo_full;
    assign imem_addr = fetch_pc_q;
    assign ir_valid  = ~fifo_empty;
    assign ir        = head.instr;
    assign ir_pc     = head.pc;

    // A redirect discards any same-cycle ack; the read has no side effects.
    assign do_push = imem_req & imem_ack & ~redirect;
    assign do_pop  = ir_valid & ir_ready & ~redirect;

    assign push_entry.instr = imem_rdata;
    assign push_entry.pc    = fetch_pc_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Redirect is honoured in IDLE as well, so the first RUN fetch goes to the target.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc & PC_MASK;
        end else if (do_push) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC & PC_MASK;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (do_push),
        .push_data(push_entry),
        .pop      (do_pop),
        .flush    (redirect),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (head)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] bubbles_q;
    logic [15:0] flushes_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bubbles_q <= '0;
            flushes_q <= '0;
        end else begin
            if ((state_q == RUN) && ir_ready && !ir_valid && (bubbles_q != '1)) begin
                bubbles_q <= bubbles_q + 32'd1;
            end
            // Only flushes that actually throw away a buffered word are counted.
            if (redirect && ir_valid && (flushes_q != '1)) begin
                flushes_q <= flushes_q + 16'd1;
            end
        end
    end

    assign perf_bubbles = bubbles_q;
    assign perf_flushes = flushes_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a queue-based reference model
module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ir_valid;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_ready;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_bubbles;
    logic [15:0] perf_flushes;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    // Memory returns a word derived from the address actually requested.
    assign imem_rdata = imem_addr ^ KEY;

    fetch_unit #(
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .ir_valid   (ir_valid),
        .ir         (ir),
        .ir_pc      (ir_pc),
        .ir_ready   (ir_ready)
`ifdef FETCH_PERF_EN
        ,
        .perf_bubbles(perf_bubbles),
        .perf_flushes(perf_flushes)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: a queue of {instr, pc} words awaiting decode.
    logic [63:0] m_q[$];
    logic [31:0] m_pc      = RESET_PC;
    bit          m_run     = 1'b0;
    logic [31:0] m_bubbles = '0;
    logic [15:0] m_flushes = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_pc      = RESET_PC;
            m_run     = 1'b0;
            m_bubbles = '0;
            m_flushes = '0;
        end else begin
            bit req_now;
            bit val_now;
            req_now = m_run && (m_q.size() < DEPTH);
            val_now = (m_q.size() != 0);
            if (m_run && ir_ready && !val_now && m_bubbles != 32'hFFFF_FFFF) m_bubbles++;
            if (redirect) begin
                if (val_now && m_flushes != 16'hFFFF) m_flushes++;
                m_q.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (val_now && ir_ready) void'(m_q.pop_front());
                if (req_now && imem_ack) begin
                    m_q.push_back({m_pc ^ KEY, m_pc});
                    m_pc = m_pc + 32'd4;
                end
            end
            m_run = 1'b1;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        logic [63:0] hd;
        chk("m_req",   {31'd0, imem_req}, {31'd0, m_run && (m_q.size() < DEPTH)});
        chk("m_addr",  imem_addr, m_pc);
        chk("m_valid", {31'd0, ir_valid}, {31'd0, m_q.size() != 0});
        if (m_q.size() != 0) begin
            hd = m_q[0];
            chk("m_ir",    ir,    hd[63:32]);
            chk("m_ir_pc", ir_pc, hd[31:0]);
        end
`ifdef FETCH_PERF_EN
        chk("m_bubbles", perf_bubbles, m_bubbles);
        chk("m_flushes", {16'd0, perf_flushes}, {16'd0, m_flushes});
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n     = 1'b1;
        imem_ack    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        ir_ready    = 1'b0;
        #1 reset_n  = 1'b0;
        tick();
        tick();
        chk("rst_req",   {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, ir_valid}, 32'd0);
        chk("rst_ir",    ir,        32'd0);
        chk("rst_ir_pc", ir_pc,     32'd0);
        chk("rst_addr",  imem_addr, 32'd0);

        // 1: streaming from reset
        imem_ack = 1'b1;
        ir_ready = 1'b1;
        #2 reset_n = 1'b1;
        tick();
        chk("t1_req",    {31'd0, imem_req}, 32'd1);
        chk("t1_addr0",  imem_addr, 32'h0);
        chk("t1_nvalid", {31'd0, ir_valid}, 32'd0);
        tick();
        chk("t1_valid",  {31'd0, ir_valid}, 32'd1);
        chk("t1_pc0",    ir_pc, 32'h0);
        chk("t1_ir0",    ir,    32'hA5A5_0000);
        chk("t1_addr4",  imem_addr, 32'h4);
        tick();
        chk("t1_pc4",    ir_pc, 32'h4);
        chk("t1_ir4",    ir,    32'hA5A5_0004);
        tick();
        chk("t1_pc8",    ir_pc, 32'h8);

        // 2: backpressure, restarted from address 0
        redirect    = 1'b1;
        redirect_pc = 32'h0;
        tick();
        redirect = 1'b0;
        ir_ready = 1'b0;
        chk("t2_flush",  {31'd0, ir_valid}, 32'd0);
        tick();
        tick();
        chk("t2_req_lo", {31'd0, imem_req}, 32'd0);
        chk("t2_addr8",  imem_addr, 32'h8);
        chk("t2_ir0",    ir, 32'hA5A5_0000);
        tick();
        chk("t2_hold8",  imem_addr, 32'h8);
        chk("t2_hold0",  ir_pc, 32'h0);
        ir_ready = 1'b1;
        tick();
        chk("t2_pc4",    ir_pc, 32'h4);
        tick();
        chk("t2_pc8",    ir_pc, 32'h8);
        chk("t2_nogap",  {31'd0, ir_valid}, 32'd1);

        // 3: memory stall
        imem_ack = 1'b0;
        ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_addr",  imem_addr, 32'hC);
            chk("t3_req",   {31'd0, imem_req}, 32'd1);
            chk("t3_valid", {31'd0, ir_valid}, 32'd1);
            chk("t3_pc",    ir_pc, 32'h8);
        end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("t3_full",   {31'd0, imem_req}, 32'd0);
        chk("t3_addr10", imem_addr, 32'h10);
        ir_ready = 1'b1;
        tick();
        chk("t3_pcC",    ir_pc, 32'hC);
        chk("t3_irC",    ir,    32'hA5A5_000C);

        // 4: redirect with a full buffer and a same-cycle ack
        ir_ready = 1'b0;
        imem_ack = 1'b1;
        tick();
        chk("t4_full",   {31'd0, imem_req}, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_1002;
        tick();
        redirect = 1'b0;
        ir_ready = 1'b1;
        chk("t4_nvalid", {31'd0, ir_valid}, 32'd0);
        chk("t4_addr",   imem_addr, 32'h1000);
        tick();
        chk("t4_pc",     ir_pc, 32'h1000);
        chk("t4_ir",     ir,    32'hA5A5_1000);
        chk("t4_addr2",  imem_addr, 32'h1004);

        // 5: address wrap, redirect discarding an acked request
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        chk("t5_nvalid", {31'd0, ir_valid}, 32'd0);
        chk("t5_addr",   imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("t5_pc",     ir_pc, 32'hFFFF_FFFC);
        chk("t5_ir",     ir,    32'h5A5A_FFFC);
        chk("t5_wrap",   imem_addr, 32'h0);
        tick();
        chk("t5_pc0",    ir_pc, 32'h0);
        imem_ack = 1'b0;
        tick();
        chk("t5_empty",  {31'd0, ir_valid}, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_2000;
        tick();
        redirect = 1'b0;
`ifdef FETCH_PERF_EN
        chk("t5_flushes", {16'd0, perf_flushes}, 32'd3);
`endif

        // 6: asynchronous reset with a non-empty buffer
        imem_ack = 1'b1;
        ir_ready = 1'b0;
        tick();
        chk("t6_pre",    {31'd0, ir_valid}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_valid",  {31'd0, ir_valid}, 32'd0);
        chk("t6_req",    {31'd0, imem_req}, 32'd0);
        chk("t6_addr",   imem_addr, RESET_PC);
        tick();
        reset_n = 1'b1;
        tick();
        chk("t6_req1",   {31'd0, imem_req}, 32'd1);
        chk("t6_addr0",  imem_addr, RESET_PC);
        tick();
        chk("t6_valid1", {31'd0, ir_valid}, 32'd1);
        chk("t6_pc0",    ir_pc, 32'h0);
        chk("t6_ir0",    ir,    32'hA5A5_0000);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
